nn_mem_responder: RTL and testbench

NN_MEM_RESPONDER -- requirements
Module: nn_mem_responder

---
 rtl/nn_mem_pkg.sv | 23 ++
 rtl/nn_mem_bank.sv | 46 ++++
 rtl/nn_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_nn_mem_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared defaults and the load/serve state type for the NN memory responder.
// Rev 1.0
`default_nettype none

package nn_mem_pkg;

  localparam int DW_DEF       = 16;
  localparam int AW_DEF       = 17;
  localparam int IN_DEPTH_DEF = 784;
  localparam int IH_DEPTH_DEF = 100352;
  localparam int HO_DEPTH_DEF = 1280;

  typedef enum logic [2:0] {
    LOAD_IN = 3'd0,
    LOAD_IH = 3'd1,
    LOAD_HO = 3'd2,
    READY   = 3'd3,
    ERROR   = 3'd4
  } nn_mem_state_t;

endpackage

`default_nettype wire

// File: rtl/nn_mem_bank.sv
// nn_mem_bank: single-write-port RAM with a one-cycle registered read port.
// Rev 1.0
`default_nettype none

module nn_mem_bank #(
  parameter int DW    = 16,
  parameter int AW    = 17,
  parameter int DEPTH = 784
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rdata;
  logic [IDXW-1:0] w_widx;
  logic [IDXW-1:0] w_ridx;

  assign w_widx  = i_waddr[IDXW-1:0];
  assign w_ridx  = i_raddr[IDXW-1:0];
  assign o_rdata = r_rdata;

  // Address bits above the bank's own index width never select a word.
  generate
    if (AW > IDXW) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{i_waddr[AW-1:IDXW], i_raddr[AW-1:IDXW]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_widx] <= i_wdata;
    end
    r_rdata <= r_mem[w_ridx];
  end

endmodule

`default_nettype wire

// File: rtl/nn_mem_responder.sv
// nn_mem_responder: streams three weight/pixel regions into RAM, then serves concurrent reads.
// Optional macro NN_MEM_RANGE_CHK_EN adds out-of-range read zeroing and the sticky rd_oor flag. Rev 1.0
`default_nettype none

module nn_mem_responder
  import nn_mem_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int IN_DEPTH = IN_DEPTH_DEF,
  parameter int IH_DEPTH = IH_DEPTH_DEF,
  parameter int HO_DEPTH = HO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] addr_in,
  input  logic [AW-1:0] addr_ih,
  input  logic [AW-1:0] addr_ho,
  output logic [DW-1:0] in,
  output logic [DW-1:0] wih,
  output logic [DW-1:0] who,
  output logic          mem_ready,
  output logic          ld_err,
  output logic          rd_oor
);

  localparam logic [AW-1:0] C_IN_LAST = AW'(IN_DEPTH - 1);
  localparam logic [AW-1:0] C_IH_LAST = AW'(IH_DEPTH - 1);
  localparam logic [AW-1:0] C_HO_LAST = AW'(HO_DEPTH - 1);

  nn_mem_state_t r_state;
  logic [AW-1:0] r_ptr;
  logic          r_ld_err;

  logic [AW-1:0] w_last_idx;
  logic          w_xfer;
  logic          w_at_end;
  logic          w_frame_ok;
  logic          w_we_in;
  logic          w_we_ih;
  logic          w_we_ho;
  logic          w_ready;
  logic [DW-1:0] w_q_in;
  logic [DW-1:0] w_q_ih;
  logic [DW-1:0] w_q_ho;

  always_comb begin
    w_last_idx = '0;
    case (r_state)
      LOAD_IN: w_last_idx = C_IN_LAST;
      LOAD_IH: w_last_idx = C_IH_LAST;
      LOAD_HO: w_last_idx = C_HO_LAST;
      default: w_last_idx = '0;
    endcase
  end

  assign ld_ready   = (r_state == LOAD_IN) || (r_state == LOAD_IH) || (r_state == LOAD_HO);
  assign w_xfer     = ld_valid && ld_ready;
  assign w_at_end   = (r_ptr == w_last_idx);
  // A word is only accepted when ld_last agrees with the region boundary.
  assign w_frame_ok = (ld_last == w_at_end);
  assign w_we_in    = w_xfer && w_frame_ok && (r_state == LOAD_IN);
  assign w_we_ih    = w_xfer && w_frame_ok && (r_state == LOAD_IH);
  assign w_we_ho    = w_xfer && w_frame_ok && (r_state == LOAD_HO);
  assign w_ready    = (r_state == READY);
  assign mem_ready  = w_ready;
  assign ld_err     = r_ld_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= LOAD_IN;
      r_ptr    <= '0;
      r_ld_err <= 1'b0;
    end else if (w_xfer) begin
      if (!w_frame_ok) begin
        r_state  <= ERROR;
        r_ld_err <= 1'b1;
      end else if (w_at_end) begin
        r_ptr <= '0;
        case (r_state)
          LOAD_IN: r_state <= LOAD_IH;
          LOAD_IH: r_state <= LOAD_HO;
          LOAD_HO: r_state <= READY;
          default: r_state <= r_state;
        endcase
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  nn_mem_bank #(.DW(DW), .AW(AW), .DEPTH(IN_DEPTH)) u_bank_in (
    .clk     (clk),
    .i_we    (w_we_in),
    .i_waddr (r_ptr),
    .i_wdata (ld_data),
    .i_raddr (addr_in),
    .o_rdata (w_q_in)
  );

  nn_mem_bank #(.DW(DW), .AW(AW), .DEPTH(IH_DEPTH)) u_bank_ih (
    .clk     (clk),
    .i_we    (w_we_ih),
    .i_waddr (r_ptr),
    .i_wdata (ld_data),
    .i_raddr (addr_ih),
    .o_rdata (w_q_ih)
  );

  nn_mem_bank #(.DW(DW), .AW(AW), .DEPTH(HO_DEPTH)) u_bank_ho (
    .clk     (clk),
    .i_we    (w_we_ho),
    .i_waddr (r_ptr),
    .i_wdata (ld_data),
    .i_raddr (addr_ho),
    .o_rdata (w_q_ho)
  );

`ifdef NN_MEM_RANGE_CHK_EN
  localparam logic [AW-1:0] C_IN_LIM = AW'(IN_DEPTH);
  localparam logic [AW-1:0] C_IH_LIM = AW'(IH_DEPTH);
  localparam logic [AW-1:0] C_HO_LIM = AW'(HO_DEPTH);

  logic r_oor_in;
  logic r_oor_ih;
  logic r_oor_ho;
  logic r_rd_oor;
  logic w_oor_in;
  logic w_oor_ih;
  logic w_oor_ho;

  assign w_oor_in = (addr_in >= C_IN_LIM);
  assign w_oor_ih = (addr_ih >= C_IH_LIM);
  assign w_oor_ho = (addr_ho >= C_HO_LIM);

  // Per-port flags travel alongside the registered read data so the zeroing lines up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oor_in <= 1'b0;
      r_oor_ih <= 1'b0;
      r_oor_ho <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_oor_in <= w_oor_in;
      r_oor_ih <= w_oor_ih;
      r_oor_ho <= w_oor_ho;
      if (w_ready && (w_oor_in || w_oor_ih || w_oor_ho)) begin
        r_rd_oor <= 1'b1;
      end
    end
  end

  assign in     = (w_ready && !r_oor_in) ? w_q_in : '0;
  assign wih    = (w_ready && !r_oor_ih) ? w_q_ih : '0;
  assign who    = (w_ready && !r_oor_ho) ? w_q_ho : '0;
  assign rd_oor = r_rd_oor;
`else
  assign in     = w_ready ? w_q_in : '0;
  assign wih    = w_ready ? w_q_ih : '0;
  assign who    = w_ready ? w_q_ho : '0;
  assign rd_oor = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nn_mem_responder.sv
// tb_nn_mem_responder: table-driven and randomized checks of load framing, reads and reset.
`default_nettype none

module tb_nn_mem_responder;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int IN_D = 20;
  localparam int IH_D = 300;
  localparam int HO_D = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [AW-1:0] addr_ih = '0;
  logic [AW-1:0] addr_ho = '0;
  logic [DW-1:0] in;
  logic [DW-1:0] wih;
  logic [DW-1:0] who;
  logic          mem_ready;
  logic          ld_err;
  logic          rd_oor;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_in [IN_D];
  logic [DW-1:0] m_ih [IH_D];
  logic [DW-1:0] m_ho [HO_D];

  typedef struct {
    int            a_in;
    int            a_ih;
    int            a_ho;
    logic [DW-1:0] e_in;
    logic [DW-1:0] e_ih;
    logic [DW-1:0] e_ho;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  nn_mem_responder #(
    .DW(DW), .AW(AW), .IN_DEPTH(IN_D), .IH_DEPTH(IH_D), .HO_DEPTH(HO_D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .addr_in   (addr_in),
    .addr_ih   (addr_ih),
    .addr_ho   (addr_ho),
    .in        (in),
    .wih       (wih),
    .who       (who),
    .mem_ready (mem_ready),
    .ld_err    (ld_err),
    .rd_oor    (rd_oor)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
    addr_in  = '0;
    addr_ih  = '0;
    addr_ho  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Offer one word, randomly idling valid at the given duty, until it is accepted.
  task automatic send(input logic [DW-1:0] d, input logic last, input int duty);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      ld_data  = d;
      ld_last  = last;
      ld_valid = ($urandom_range(99) < duty);
      done     = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL ld_timeout: word not accepted after %0d cycles, required acceptance", guard);
        done = 1'b1;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  function automatic int depth_of(input int r);
    return (r == 0) ? IN_D : ((r == 1) ? IH_D : HO_D);
  endfunction

  task automatic load_all(input bit rnd, input int duty);
    logic [DW-1:0] d;
    int            dep;
    for (int r = 0; r < 3; r++) begin
      dep = depth_of(r);
      for (int i = 0; i < dep; i++) begin
        d = rnd ? DW'($urandom) : DW'(i);
        if (r == 0) m_in[i] = d;
        else if (r == 1) m_ih[i] = d;
        else m_ho[i] = d;
        if (r == 2 && i == dep - 1) check("mem_ready_before_last", 32'(mem_ready), 32'd0);
        send(d, (i == dep - 1), duty);
      end
    end
    check("mem_ready_after_last", 32'(mem_ready), 32'd1);
    check("ld_err_after_load", 32'(ld_err), 32'd0);
    check("ld_ready_in_ready", 32'(ld_ready), 32'd0);
  endtask

  task automatic rd(input int ai, input int ah, input int ao);
    addr_in = AW'(ai);
    addr_ih = AW'(ah);
    addr_ho = AW'(ao);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, ah, ao;

    tbl[0] = '{5, 299, 39, 16'd5, 16'd299, 16'd39};
    tbl[1] = '{0, 0, 0, 16'd0, 16'd0, 16'd0};
    tbl[2] = '{19, 150, 20, 16'd19, 16'd150, 16'd20};
    tbl[3] = '{1, 298, 0, 16'd1, 16'd298, 16'd0};
    tbl[4] = '{12, 1, 38, 16'd12, 16'd1, 16'd38};
    tbl[5] = '{19, 299, 39, 16'd19, 16'd299, 16'd39};

    // Reset state
    do_reset();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_rd_oor", 32'(rd_oor), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_outputs", {in, wih}, 32'd0);
    check("rst_who", 32'(who), 32'd0);

    // Index-pattern load at full rate, then table-driven reads
    load_all(1'b0, 100);
    for (int k = 0; k < 6; k++) begin
      rd(tbl[k].a_in, tbl[k].a_ih, tbl[k].a_ho);
      check($sformatf("tbl%0d_in", k), 32'(in), 32'(tbl[k].e_in));
      check($sformatf("tbl%0d_wih", k), 32'(wih), 32'(tbl[k].e_ih));
      check($sformatf("tbl%0d_who", k), 32'(who), 32'(tbl[k].e_ho));
    end
    check("rd_oor_inrange", 32'(rd_oor), 32'd0);

    // Out-of-range read behaviour depends on build configuration
`ifdef NN_MEM_RANGE_CHK_EN
    rd(IN_D, 7, 8);
    check("oor_in_zero", 32'(in), 32'd0);
    check("oor_flag_set", 32'(rd_oor), 32'd1);
    check("oor_wih_unaffected", 32'(wih), 32'd7);
    rd(3, 4, 5);
    check("oor_flag_sticky", 32'(rd_oor), 32'd1);
    check("oor_in_recovers", 32'(in), 32'd3);
`else
    rd(IN_D, 7, 8);
    check("oor_flag_tied", 32'(rd_oor), 32'd0);
    check("oor_wih_unaffected", 32'(wih), 32'd7);
`endif

    // Reset from READY drops outputs immediately
    rd(9, 9, 9);
    check("pre_rst_in", 32'(in), 32'd9);
    rst = 1'b0;
    #1;
    check("async_rst_in", 32'(in), 32'd0);
    check("async_rst_mem_ready", 32'(mem_ready), 32'd0);
    check("async_rst_rd_oor", 32'(rd_oor), 32'd0);

    // Index-pattern load with 30% valid duty: full sweep of all three regions
    do_reset();
    load_all(1'b0, 30);
    for (int i = 0; i < IH_D; i++) begin
      rd(i % IN_D, i, i % HO_D);
      check("sweep_in", 32'(in), 32'(i % IN_D));
      check("sweep_wih", 32'(wih), 32'(i));
      check("sweep_who", 32'(who), 32'(i % HO_D));
    end

    // Random data, random reads against the model
    do_reset();
    load_all(1'b1, 60);
    for (int k = 0; k < 60; k++) begin
      ai = $urandom_range(IN_D - 1);
      ah = $urandom_range(IH_D - 1);
      ao = $urandom_range(HO_D - 1);
      rd(ai, ah, ao);
      check("rand_in", 32'(in), 32'(m_in[ai]));
      check("rand_wih", 32'(wih), 32'(m_ih[ah]));
      check("rand_who", 32'(who), 32'(m_ho[ao]));
    end

    // Early ld_last on IN word 10
    do_reset();
    for (int i = 0; i <= 10; i++) send(DW'(i), (i == 10), 100);
    check("early_last_err", 32'(ld_err), 32'd1);
    check("early_last_ready", 32'(ld_ready), 32'd0);
    check("early_last_mem_ready", 32'(mem_ready), 32'd0);
    ld_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 ld_valid = 1'b0;
    check("error_held_err", 32'(ld_err), 32'd1);
    check("error_held_mem_ready", 32'(mem_ready), 32'd0);
    check("error_held_in", 32'(in), 32'd0);

    // Missing ld_last on the final IN word
    do_reset();
    check("err_cleared_by_rst", 32'(ld_err), 32'd0);
    for (int i = 0; i < IN_D; i++) send(DW'(i), 1'b0, 100);
    check("missing_last_err", 32'(ld_err), 32'd1);
    check("missing_last_ready", 32'(ld_ready), 32'd0);

    // Reset in the middle of the IH region, then a full reload
    do_reset();
    for (int i = 0; i < IN_D; i++) send(DW'(i), (i == IN_D - 1), 100);
    for (int i = 0; i < 150; i++) send(DW'(i), 1'b0, 100);
    rst = 1'b0;
    #1;
    check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    check("mid_rst_ld_err", 32'(ld_err), 32'd0);
    check("mid_rst_outputs", {in, wih}, 32'd0);
    do_reset();
    load_all(1'b1, 100);
    for (int k = 0; k < 20; k++) begin
      ai = $urandom_range(IN_D - 1);
      ah = $urandom_range(IH_D - 1);
      ao = $urandom_range(HO_D - 1);
      rd(ai, ah, ao);
      check("reload_in", 32'(in), 32'(m_in[ai]));
      check("reload_wih", 32'(wih), 32'(m_ih[ah]));
      check("reload_who", 32'(who), 32'(m_ho[ao]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
